input_fifo_packet_drop: RTL

Per-port input buffer of the credit-based router, sitting directly upstream of the packet-dropping LBDR stage. Stores incoming flits, presents the head flit's type, destination and fault status to LBDR, and pops flits on a crossbar grant. While LBDR asserts its drop order, it autonomously discards flits, returning one credit per discarded flit, until the packet's tail has been removed.

---
 rtl/input_fifo_packet_drop.sv | 110 +++++++++++
 1 files changed

// File: rtl/input_fifo_packet_drop.sv
// Per-port input FIFO for the credit-based router, with LBDR-driven packet discard.
// Optional head-flit parity checking is built when FIFO_PARITY_CHECK_EN is defined.
module input_fifo_packet_drop #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int NoC_size   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  valid_in,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  input  logic                  packet_drop_order,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic [2:0]            flit_type,
  output logic [NoC_size-1:0]   dst_addr,
  output logic                  faulty,
  output logic                  empty,
  output logic                  full,
  output logic                  credit_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE    = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   FULL_COUNT = FIFO_DEPTH[PTR_W:0];

`ifdef FIFO_PARITY_CHECK_EN
  function automatic logic parity_odd(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W:0]        count_r;
  logic                  credit_r;
  logic                  pop_s;
  logic                  write_s;
  logic                  any_read_s;

  // Status flags come from the registered occupancy only
  always_comb begin
    empty = (count_r == {(PTR_W+1){1'b0}});
    full  = (count_r == FULL_COUNT);
  end

  // Pop and write qualification; full is judged before any same-cycle pop
  always_comb begin
    pop_s      = 1'b0;
    write_s    = 1'b0;
    any_read_s = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
    if (!empty && (any_read_s || packet_drop_order)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (valid_in && !full) begin
      write_s = 1'b1;
    end else begin
      write_s = 1'b0;
    end
  end

  // Storage, pointers, occupancy and credit pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      credit_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      credit_r <= pop_s;
      if (write_s) begin
        mem_r[wr_ptr_r] <= RX;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({write_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head flit view for LBDR, combinational from the read pointer
  always_comb begin
    Data_out  = mem_r[rd_ptr_r];
    flit_type = Data_out[DATA_WIDTH-1 -: 3];
    dst_addr  = Data_out[NoC_size:1];
    credit_out = credit_r;
`ifdef FIFO_PARITY_CHECK_EN
    faulty = ~empty & parity_odd(Data_out);
`else
    faulty = 1'b0;
`endif
  end

endmodule
